// File: rtl/aes_inv_sub_bytes_serial_if.sv
// Handshake bundle for the byte-serial AES inverse SubBytes engine.
// Ports: in_valid/in_ready/in_data (request), out_valid/out_ready/out_data (result).
interface aes_inv_sub_bytes_serial_if #(
    parameter int NBYTES = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_inv_sub_bytes_serial.sv
// Byte-serial AES inverse SubBytes: one shared InvSbox, one byte per cycle.
// Ports: clk, rst (sync, active-high), bus (slave side of the handshake bundle).
module aes_inv_sub_bytes_serial #(
    parameter int NBYTES = 16
) (
    input logic clk,
    input logic rst,
    aes_inv_sub_bytes_serial_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q;
    logic [W-1:0]    sr_q;
    logic [W-1:0]    sr_d;
    logic [W-1:0]    out_data_q;
    logic [CW-1:0]   cnt_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [7:0]      sub_d;

    // MSB byte goes through the S-box and re-enters at the LSB end, so after
    // NBYTES rotations every byte is back in its original lane.
    assign sub_d = INV_SBOX[sr_q[W-1 -: 8]];

    generate
        if (NBYTES == 1) begin : g_one
            assign sr_d = sub_d;
        end else begin : g_many
            assign sr_d = {sr_q[W-9:0], sub_d};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sr_q       <= bus.in_data;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    sr_q <= sr_d;
                    if (cnt_q == LAST) begin
                        // Wrap to zero so the counter never reaches NBYTES.
                        cnt_q       <= '0;
                        out_data_q  <= sr_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_aes_inv_sub_bytes_serial.sv
// Directed and round-trip bench for aes_inv_sub_bytes_serial.
// Instances: NBYTES = 16, 4 and 1 sharing clk and rst.
module tb_aes_inv_sub_bytes_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    aes_inv_sub_bytes_serial_if #(.NBYTES(16)) bus16 ();
    aes_inv_sub_bytes_serial_if #(.NBYTES(4))  bus4 ();
    aes_inv_sub_bytes_serial_if #(.NBYTES(1))  bus1 ();

    aes_inv_sub_bytes_serial #(.NBYTES(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    aes_inv_sub_bytes_serial #(.NBYTES(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    aes_inv_sub_bytes_serial #(.NBYTES(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));

    localparam logic [7:0] FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [127:0] fwd128(input logic [127:0] x);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = FWD[x[8*k +: 8]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drv(input int sel, input logic v, input logic [127:0] d);
        case (sel)
            1: begin bus1.in_valid = v; bus1.in_data = d[7:0]; end
            4: begin bus4.in_valid = v; bus4.in_data = d[31:0]; end
            default: begin bus16.in_valid = v; bus16.in_data = d; end
        endcase
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            1: return bus1.in_ready;
            4: return bus4.in_ready;
            default: return bus16.in_ready;
        endcase
    endfunction

    function automatic logic ov(input int sel);
        case (sel)
            1: return bus1.out_valid;
            4: return bus4.out_valid;
            default: return bus16.out_valid;
        endcase
    endfunction

    function automatic logic [127:0] od(input int sel);
        case (sel)
            1: return {120'd0, bus1.out_data};
            4: return {96'd0, bus4.out_data};
            default: return bus16.out_data;
        endcase
    endfunction

    // One transaction with out_ready high: checks latency, data, return to IDLE.
    task automatic xfer(input int sel, input logic [127:0] din,
                        input logic [127:0] exp, input string tag);
        int n;
        int lat;
        n = 0;
        while (!rdy(sel) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        drv(sel, 1'b1, din);
        @(posedge clk); #1;
        drv(sel, 1'b0, din);
        lat = 0;
        while (!ov(sel) && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, ".lat"}, 128'(lat), 128'(sel));
        check({tag, ".data"}, od(sel), exp);
        @(posedge clk); #1;
        check({tag, ".idle"}, 128'(rdy(sel)), 128'd1);
    endtask

    localparam logic [127:0] MIX_IN  = 128'h7C360540_63000016_FF7C3605_4063FF00;
    localparam logic [127:0] MIX_OUT = 128'h01243672_005252FF_7D012436_72007D52;

    initial begin
        logic [127:0] v [3];
        logic [127:0] e [3];
        logic [127:0] hold;
        logic [127:0] x;
        int acc;
        int res;
        int cyc;
        int last;
        int hits;

        bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.out_ready = 1'b1;
        bus4.in_valid  = 1'b0; bus4.in_data  = '0; bus4.out_ready  = 1'b1;
        bus1.in_valid  = 1'b0; bus1.in_data  = '0; bus1.out_ready  = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst.ready", 128'(bus16.in_ready), 128'd1);
        check("rst.valid", 128'(bus16.out_valid), 128'd0);
        check("rst.data", bus16.out_data, 128'd0);

        xfer(4, 128'h7C360540, 128'h01243672, "w4");
        xfer(1, 128'h7C, 128'h01, "b1");
        xfer(1, 128'h00, 128'h52, "b1z");

        xfer(16, {16{8'h63}}, {16{8'h00}}, "c63");
        xfer(16, {16{8'h00}}, {16{8'h52}}, "c00");
        xfer(16, {16{8'h16}}, {16{8'hFF}}, "c16");
        xfer(16, {16{8'hFF}}, {16{8'h7D}}, "cFF");
        xfer(16, MIX_IN, MIX_OUT, "mix");

        // Abort mid-BUSY; in_valid held during reset must not be captured.
        drv(16, 1'b1, {16{8'h16}});
        @(posedge clk); #1;
        drv(16, 1'b0, '0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        drv(16, 1'b1, {16{8'h63}});
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        drv(16, 1'b0, '0);
        check("abort.ready", 128'(bus16.in_ready), 128'd1);
        check("abort.valid", 128'(bus16.out_valid), 128'd0);
        check("abort.data", bus16.out_data, 128'd0);
        hits = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus16.out_valid) hits++;
        end
        check("abort.noout", 128'(hits), 128'd0);

        // Backpressure.
        bus16.out_ready = 1'b0;
        drv(16, 1'b1, MIX_IN);
        @(posedge clk); #1;
        drv(16, 1'b0, '0);
        cyc = 0;
        while (!bus16.out_valid && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check("bp.lat", 128'(cyc), 128'd16);
        hold = bus16.out_data;
        check("bp.data", hold, MIX_OUT);
        for (int i = 0; i < 10; i++) begin
            drv(16, i[0], {4{$urandom}});
            @(posedge clk); #1;
            check($sformatf("bp.v%0d", i), 128'(bus16.out_valid), 128'd1);
            check($sformatf("bp.r%0d", i), 128'(bus16.in_ready), 128'd0);
            check($sformatf("bp.d%0d", i), bus16.out_data, MIX_OUT);
        end
        drv(16, 1'b0, '0);
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.rel.ready", 128'(bus16.in_ready), 128'd1);
        check("bp.rel.valid", 128'(bus16.out_valid), 128'd0);
        hits = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus16.out_valid) hits++;
        end
        check("bp.nocap", 128'(hits), 128'd0);
        check("bp.hold", bus16.out_data, MIX_OUT);

        // Back-to-back with in_valid and out_ready held high.
        v[0] = {16{8'h63}}; e[0] = {16{8'h00}};
        v[1] = {16{8'h16}}; e[1] = {16{8'hFF}};
        v[2] = MIX_IN;      e[2] = MIX_OUT;
        acc = 0; res = 0; cyc = 0; last = 0;
        drv(16, 1'b1, v[0]);
        while (res < 3 && cyc < 200) begin
            if (bus16.out_valid) begin
                check($sformatf("b2b.res%0d", res), bus16.out_data, e[res]);
                res++;
            end
            if (bus16.in_ready && bus16.in_valid) begin
                if (acc > 0)
                    check($sformatf("b2b.gap%0d", acc), 128'(cyc - last), 128'd18);
                last = cyc;
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc >= 3) drv(16, 1'b0, '0);
            else drv(16, 1'b1, v[acc]);
        end
        check("b2b.count", 128'(res), 128'd3);
        drv(16, 1'b0, '0);
        @(posedge clk); #1;

        // Round trip: forward S-box in the bench, inverse in the DUT.
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 16; k++) x[8*k +: 8] = 8'(16 * i + k);
            xfer(16, fwd128(x), x, $sformatf("all%0d", i));
        end
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            xfer(16, fwd128(x), x, $sformatf("rt%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
